// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared state encoding, slave address map and decode for the APB round-robin arbiter
package apb_arb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_DECERR, S_DONE} state_e;
  localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
  localparam logic [31:0] SLV_MASK  = 32'hFC00_0000;
  localparam logic [2:0]  PSEL_NONE = 3'b000;
  function automatic logic [2:0] apb_decode(input logic [31:0] addr);
    return ((addr & SLV_MASK) == SLV0_BASE) ? 3'b001 :
           ((addr & SLV_MASK) == SLV1_BASE) ? 3'b010 :
           ((addr & SLV_MASK) == SLV2_BASE) ? 3'b100 : PSEL_NONE;
  endfunction
endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: rotate-priority picker, first set request searching upward from ptr_i+1 with wrap
module apb_rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);
  int k;
  // scan farthest-first so the nearest set request after ptr_i overwrites the rest
  always_comb begin
    idx_o = '0;
    k = 0;
    for (int i = NREQ; i >= 1; i--) begin
      k = (int'(ptr_i) + i) % NREQ;
      if (req_i[k]) idx_o = IW'(k);
    end
    gnt_o = (|req_i) ? (NREQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin sharing of one APB master port between NREQ requesters,
// with address decode, PREADY wait states and an access timeout.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ-1:0]  req_write_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [NREQ-1:0]  done_o,
  output logic             err_o,
  output logic [DW-1:0]    rdata_o,
  output logic [AW-1:0]    paddr,
  output logic [DW-1:0]    pwdata,
  output logic             pwrite,
  output logic [2:0]       pselx,
  output logic             penable,
  input  logic             pready,
  input  logic [DW-1:0]    prdata,
  input  logic             pslverr
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            pwrite_q, pwrite_d;
  logic [2:0]      sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic            win_write;
  logic [2:0]      win_sel;
  apb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        win_addr  = req_addr_i[i*AW +: AW];
        win_wdata = req_wdata_i[i*DW +: DW];
        win_write = req_write_i[i];
      end
    end
    win_sel = apb_decode(32'(win_addr));
  end
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: if (|req_i) begin
        gnt_d    = pick_gnt;
        ptr_d    = pick_idx;
        paddr_d  = win_addr;
        pwdata_d = win_wdata;
        pwrite_d = win_write;
        sel_d    = win_sel;
        err_d    = 1'b0;
        state_d  = (win_sel == PSEL_NONE) ? S_DECERR : S_SETUP;
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      // the final waiting cycle is the TIMEOUT-th ACCESS cycle
      S_ACCESS: if (pready) begin
        rdata_d = pwrite_q ? rdata_q : prdata;
        err_d   = pslverr;
        state_d = S_DONE;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_DECERR: begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    gnt_o   = (state_q == S_SETUP || state_q == S_ACCESS || state_q == S_DECERR) ? gnt_q : '0;
    done_o  = (state_q == S_DONE) ? gnt_q : '0;
    err_o   = (state_q == S_DONE) & err_q;
    pselx   = (state_q == S_SETUP || state_q == S_ACCESS) ? sel_q : PSEL_NONE;
    penable = (state_q == S_ACCESS);
    rdata_o = rdata_q;
    paddr   = paddr_q;
    pwdata  = pwdata_q;
    pwrite  = pwrite_q;
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= S_IDLE;
      ptr_q    <= IW'(NREQ - 1);
      gnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= PSEL_NONE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: scenario tasks plus a completion scoreboard for apb_rr_arbiter
module tb_apb_rr_arbiter;
  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [3:0]  req_v = '0;
  logic [3:0]  wr_v = '0;
  logic [31:0] addr_v [4];
  logic [31:0] wdata_v [4];
  logic [3:0]  gnt_o, done_o;
  logic        err_o;
  logic [31:0] rdata_o, paddr, pwdata, prdata;
  logic        pwrite, penable;
  logic [2:0]  pselx;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;
  logic        use_model = 1'b0;
  logic [31:0] prdata_v = '0;
  logic [31:0] last_rd = '0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb [$];
  exp_t        e;

  always #5 hclk = ~hclk;
  assign prdata = use_model ? (paddr ^ 32'hA5A5_0000) : prdata_v;

  apb_rr_arbiter #(.NREQ(4), .TIMEOUT(16), .AW(32), .DW(32)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .req_i       (req_v),
    .req_write_i (wr_v),
    .req_addr_i  ({addr_v[3], addr_v[2], addr_v[1], addr_v[0]}),
    .req_wdata_i ({wdata_v[3], wdata_v[2], wdata_v[1], wdata_v[0]}),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pwrite      (pwrite),
    .pselx       (pselx),
    .penable     (penable),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  always @(negedge hclk) begin
    if (hresetn && |done_o) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: done_o=%b with no pending transfer", done_o);
      end else begin
        e = sb.pop_front();
        if (done_o !== (4'b0001 << e.idx) || err_o !== e.err || rdata_o !== e.rdata) begin
          bad++;
          $display("FAIL sb_done: got done=%b err=%b rdata=%h, expected done=%b err=%b rdata=%h",
                   done_o, err_o, rdata_o, 4'b0001 << e.idx, e.err, e.rdata);
        end
      end
    end
  end

  task automatic push(input int idx, input logic err, input logic [31:0] rd);
    exp_t x;
    x.idx = idx;
    x.err = err;
    x.rdata = rd;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic wait_done(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (|done_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    repeat (2) tick();
    total++;
    if ({gnt_o, done_o, err_o, pselx, penable, pwrite} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got gnt=%b done=%b err=%b psel=%b pen=%b pwr=%b, expected all 0",
               gnt_o, done_o, err_o, pselx, penable, pwrite);
    end
    total++;
    if ({paddr, pwdata, rdata_o} !== '0) begin
      bad++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h, expected 0", paddr, pwdata, rdata_o);
    end
    hresetn = 1'b1;
    tick();
    total++;
    if (gnt_o !== 4'b0 || pselx !== 3'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got gnt=%b psel=%b, expected 0", gnt_o, pselx);
    end
  endtask

  task automatic test_single_read();
    use_model = 1'b0;
    prdata_v = 32'hDEAD_BEEF;
    pready = 1'b1;
    wr_v[0] = 1'b0;
    addr_v[0] = 32'h8000_0010;
    req_v = 4'b0001;
    push(0, 1'b0, 32'hDEAD_BEEF);
    last_rd = 32'hDEAD_BEEF;
    tick();
    total++;
    if (pselx !== 3'b001 || penable !== 1'b0 || gnt_o !== 4'b0001 || paddr !== 32'h8000_0010 || pwrite !== 1'b0) begin
      bad++;
      $display("FAIL rd_setup: got psel=%b pen=%b gnt=%b paddr=%h pwr=%b, expected 001 0 0001 80000010 0",
               pselx, penable, gnt_o, paddr, pwrite);
    end
    tick();
    total++;
    if (pselx !== 3'b001 || penable !== 1'b1) begin
      bad++;
      $display("FAIL rd_access: got psel=%b pen=%b, expected 001 1", pselx, penable);
    end
    tick();
    total++;
    if (done_o !== 4'b0001 || err_o !== 1'b0 || rdata_o !== 32'hDEAD_BEEF || pselx !== 3'b0 || penable !== 1'b0 || gnt_o !== 4'b0) begin
      bad++;
      $display("FAIL rd_done: got done=%b err=%b rdata=%h psel=%b pen=%b gnt=%b, expected 0001 0 deadbeef 000 0 0000",
               done_o, err_o, rdata_o, pselx, penable, gnt_o);
    end
    req_v = 4'b0;
    tick();
    total++;
    if (done_o !== 4'b0 || rdata_o !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL rd_pulse: got done=%b rdata=%h, expected 0000 deadbeef", done_o, rdata_o);
    end
  endtask

  task automatic test_wait_err();
    pready = 1'b0;
    pslverr = 1'b1;
    wr_v[1] = 1'b1;
    addr_v[1] = 32'h8400_0004;
    wdata_v[1] = 32'h1122_3344;
    req_v = 4'b0010;
    push(1, 1'b1, last_rd);
    tick();
    total++;
    if (pselx !== 3'b010 || penable !== 1'b0 || gnt_o !== 4'b0010) begin
      bad++;
      $display("FAIL wr_setup: got psel=%b pen=%b gnt=%b, expected 010 0 0010", pselx, penable, gnt_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (penable !== 1'b1 || pselx !== 3'b010 || paddr !== 32'h8400_0004 || pwdata !== 32'h1122_3344 || pwrite !== 1'b1 || done_o !== 4'b0) begin
        bad++;
        $display("FAIL wr_wait%0d: got pen=%b psel=%b paddr=%h pwdata=%h pwr=%b done=%b, expected stable access",
                 i, penable, pselx, paddr, pwdata, pwrite, done_o);
      end
      if (i == 3) pready = 1'b1;
    end
    tick();
    total++;
    if (done_o !== 4'b0010 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL wr_done: got done=%b err=%b, expected 0010 1", done_o, err_o);
    end
    req_v = 4'b0;
    pslverr = 1'b0;
    tick();
  endtask

  task automatic test_decerr();
    int n;
    wr_v[2] = 1'b0;
    addr_v[2] = 32'h9000_0000;
    req_v = 4'b0100;
    push(2, 1'b1, last_rd);
    tick();
    total++;
    if (pselx !== 3'b0 || penable !== 1'b0) begin
      bad++;
      $display("FAIL dec_quiet: got psel=%b pen=%b, expected 000 0", pselx, penable);
    end
    wait_done(5, n);
    total++;
    if (n !== 1 || done_o !== 4'b0100 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL dec_done: got extra_cycles=%0d done=%b err=%b, expected 1 0100 1", n, done_o, err_o);
    end
    req_v = 4'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    logic seen = 1'b0;
    pready = 1'b0;
    wr_v[3] = 1'b0;
    addr_v[3] = 32'h8800_0000;
    req_v = 4'b1000;
    push(3, 1'b1, last_rd);
    tick();
    total++;
    if (pselx !== 3'b100) begin
      bad++;
      $display("FAIL to_setup: got psel=%b, expected 100", pselx);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (|done_o) begin
        seen = 1'b1;
        break;
      end
      if (penable) n++;
    end
    total++;
    if (!seen || n !== 16 || done_o !== 4'b1000 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL to_done: got seen=%b access_cycles=%0d done=%b err=%b, expected 1 16 1000 1",
               seen, n, done_o, err_o);
    end
    req_v = 4'b0;
    pready = 1'b1;
    tick();
  endtask

  task automatic test_mid_reset();
    pready = 1'b0;
    wr_v[0] = 1'b0;
    addr_v[0] = 32'h8000_0020;
    req_v = 4'b0001;
    repeat (3) tick();
    total++;
    if (penable !== 1'b1) begin
      bad++;
      $display("FAIL mr_in_access: got pen=%b, expected 1", penable);
    end
    #2 hresetn = 1'b0;
    #1;
    total++;
    if ({gnt_o, done_o, err_o, pselx, penable, pwrite} !== '0 || {paddr, pwdata, rdata_o} !== '0) begin
      bad++;
      $display("FAIL mr_async: got gnt=%b done=%b err=%b psel=%b pen=%b paddr=%h rdata=%h, expected 0",
               gnt_o, done_o, err_o, pselx, penable, paddr, rdata_o);
    end
    repeat (2) tick();
    req_v = 4'b0;
    pready = 1'b1;
    last_rd = '0;
    hresetn = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int n;
    int t = 0;
    use_model = 1'b1;
    pready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_v[k] = 1'b0;
      addr_v[k] = 32'h8000_0100 + 32'(k * 4);
    end
    for (int j = 0; j < 5; j++) begin
      push(order[j], 1'b0, addr_v[order[j]] ^ 32'hA5A5_0000);
      last_rd = addr_v[order[j]] ^ 32'hA5A5_0000;
    end
    req_v = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(8, n);
      if (j == 4) req_v = 4'b0;
      total++;
      if (n !== (j == 0 ? 3 : 4) || done_o !== (4'b0001 << order[j])) begin
        bad++;
        $display("FAIL rr_grant%0d: got cycles=%0d done=%b, expected %0d %b",
                 j, n, done_o, (j == 0 ? 3 : 4), 4'b0001 << order[j]);
      end
      if (n < 0) break;
      t++;
    end
    repeat (3) tick();
    total++;
    if (sb.size() != 0 || t != 5) begin
      bad++;
      $display("FAIL sb_drain: got pending=%0d completions=%0d, expected 0 5", sb.size(), t);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      addr_v[k] = '0;
      wdata_v[k] = '0;
    end
    test_reset();
    test_single_read();
    test_wait_err();
    test_decerr();
    test_timeout();
    test_mid_reset();
    test_round_robin();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
